name_record_packer: RTL

//  Writer side of the name-record word format. Packs a byte stream of FASTQ read-name

---
 rtl/name_record_packer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/name_record_packer.sv
// name_record_packer: buffers one FASTQ read name and emits it as 160-bit
// count-prefixed words; optional trailer word via NAME_PACK_TRAILER_EN.
module name_record_packer #(
  parameter int CHAR_W    = 8,
  parameter int PAY_W     = 128,
  parameter int CNT_W     = 32,
  parameter int MAX_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CHAR_W-1:0]      in_char,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [PAY_W+CNT_W-1:0] out_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_first,
  output logic                   overflow
);

  localparam int CPW   = PAY_W / CHAR_W;
  localparam int IDX_W = $clog2(CPW);
  localparam int WC_W  = ADDR_W + 1;
  localparam int CH_W  = ADDR_W + IDX_W + 1;
`ifdef NAME_PACK_TRAILER_EN
  localparam logic [WC_W-1:0] TRL = WC_W'(1);
`else
  localparam logic [WC_W-1:0] TRL = '0;
`endif

  typedef enum logic {FILL, EMIT} state_t;

  state_t             state_q, state_d;
  logic [PAY_W-1:0]   buf_q [MAX_WORDS];
  logic [PAY_W-1:0]   buf_d [MAX_WORDS];
  logic [PAY_W-1:0]   pay_q, pay_d, pay_n;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WC_W-1:0]    wc_q, wc_d;
  logic [WC_W-1:0]    rd_q, rd_d;
  logic               ovf_done_q, ovf_done_d;
  logic [WC_W-1:0]    total, remain;
  logic [PAY_W-1:0]   payload;
  logic               full, acc;
`ifdef NAME_PACK_TRAILER_EN
  logic [CH_W-1:0]    chars_q, chars_d;
`endif

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    pay_d      = pay_q;
    idx_d      = idx_q;
    wc_d       = wc_q;
    rd_d       = rd_q;
    ovf_done_d = ovf_done_q;
`ifdef NAME_PACK_TRAILER_EN
    chars_d    = chars_q;
`endif
    pay_n      = pay_q;
    payload    = '0;
    out_word   = '0;
    out_valid  = 1'b0;
    out_first  = 1'b0;
    in_ready   = (state_q == FILL);
    full       = (wc_q == WC_W'(MAX_WORDS));
    acc        = in_valid && in_ready;
    overflow   = acc && full && !in_last && !ovf_done_q;
    total      = wc_q + TRL;
    remain     = total - rd_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          if (!full) begin
            pay_n = pay_q | ({{(PAY_W-CHAR_W){1'b0}}, in_char}
                             << (idx_q * CHAR_W));
`ifdef NAME_PACK_TRAILER_EN
            chars_d = chars_q + CH_W'(1);
`endif
            if (idx_q == IDX_W'(CPW-1) || in_last) begin
              buf_d[wc_q[ADDR_W-1:0]] = pay_n;
              wc_d  = wc_q + WC_W'(1);
              pay_d = '0;
              idx_d = '0;
            end else begin
              pay_d = pay_n;
              idx_d = idx_q + IDX_W'(1);
            end
          end
          if (overflow) ovf_done_d = 1'b1;
          if (in_last) begin
            state_d = EMIT;
            rd_d    = '0;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_first = (rd_q == '0);
`ifdef NAME_PACK_TRAILER_EN
        // the slot past the last data word is the character-count trailer
        if (rd_q < wc_q) payload = buf_q[rd_q[ADDR_W-1:0]];
        else payload = {{(PAY_W-CH_W){1'b0}}, chars_q};
`else
        payload = buf_q[rd_q[ADDR_W-1:0]];
`endif
        out_word = {payload, {(CNT_W-WC_W){1'b0}}, remain};
        if (out_ready) begin
          if (remain == WC_W'(1)) begin
            state_d    = FILL;
            wc_d       = '0;
            rd_d       = '0;
            ovf_done_d = 1'b0;
`ifdef NAME_PACK_TRAILER_EN
            chars_d    = '0;
`endif
          end else begin
            rd_d = rd_q + WC_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      buf_q      <= '{default: '0};
      pay_q      <= '0;
      idx_q      <= '0;
      wc_q       <= '0;
      rd_q       <= '0;
      ovf_done_q <= 1'b0;
`ifdef NAME_PACK_TRAILER_EN
      chars_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      pay_q      <= pay_d;
      idx_q      <= idx_d;
      wc_q       <= wc_d;
      rd_q       <= rd_d;
      ovf_done_q <= ovf_done_d;
`ifdef NAME_PACK_TRAILER_EN
      chars_q    <= chars_d;
`endif
    end
  end

endmodule
